// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: programmable serial pattern-scan controller with valid/ready config and match counting.
// Define SCAN_MASK_EN to add a cfg_mask port that marks pattern positions as don't-care.
module seq_scan_ctrl #(
    parameter int PW = 8,
    parameter int LW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
`ifdef SCAN_MASK_EN
    input  logic [PW-1:0] cfg_mask,
`endif
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          in,
    output logic          match,
    output logic [CW-1:0] match_count,
    output logic          done,
    output logic          busy,
    output logic [1:0]    present,
    output logic [1:0]    next
);
    typedef enum logic [1:0] {IDLE = 2'b00, READY = 2'b01, SCAN = 2'b10, DONE = 2'b11} state_t;
    state_t state, state_nx;
    logic [PW-1:0] pat, msk, hist, window, len_mask;
    logic [LW-1:0] len, fill;
    logic [CW-1:0] tgt, cnt;
    logic ovl, cfg_fire, cfg_ok, hit, last_hit;
    assign cfg_ready = state != SCAN;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign cfg_ok    = cfg_len != '0 && cfg_len <= LW'(PW);
    assign window    = {hist[PW-2:0], in};
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PW; i++) len_mask[i] = i < int'(len);
    end
    assign hit      = ((window ^ pat) & len_mask & ~msk) == '0;
    assign match    = state == SCAN && in_valid && !abort && fill >= len - 1'b1 && hit;
    assign last_hit = tgt != '0 && cnt + 1'b1 == tgt;
    // Config outranks abort, abort outranks start; an illegal config still swallows start.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cfg_fire && cfg_ok ? READY : IDLE;
            READY:   state_nx = !cfg_fire && start ? SCAN : READY;
            SCAN:    state_nx = abort ? READY : match && last_hit ? DONE : SCAN;
            default: state_nx = cfg_fire ? (cfg_ok ? READY : DONE) : abort ? READY : start ? SCAN : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat  <= '0;
            len  <= '0;
            ovl  <= 1'b0;
            tgt  <= '0;
            hist <= '0;
            fill <= '0;
            cnt  <= '0;
        end else begin
            if (cfg_fire && cfg_ok) begin
                pat <= cfg_pattern;
                len <= cfg_len;
                ovl <= cfg_overlap;
                tgt <= cfg_target;
            end
            if (state != SCAN && state_nx == SCAN) begin
                hist <= '0;
                fill <= '0;
                cnt  <= '0;
            end else if (state == SCAN && in_valid && !abort) begin
                hist <= window;
                fill <= match && !ovl ? '0 : fill == len ? fill : fill + 1'b1;
                if (match && cnt != '1) cnt <= cnt + 1'b1;
            end
        end
    end
`ifdef SCAN_MASK_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset)                 msk <= '0;
        else if (cfg_fire && cfg_ok) msk <= cfg_mask;
`else
    assign msk = '0;
`endif
    assign match_count = cnt;
    assign done        = state == DONE;
    assign busy        = state == SCAN;
    assign present     = state;
    assign next        = state_nx;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed test-plan sequences plus random traffic checked against a bit-queue model.
module tb_seq_scan_ctrl;
    localparam int PW = 8, LW = 4, CW = 8;
    localparam int S_IDLE = 0, S_READY = 1, S_SCAN = 2, S_DONE = 3;
    logic clk = 1'b0, reset = 1'b0;
    logic cfg_valid = 0, cfg_overlap = 0, start = 0, abort = 0, in_valid = 0, in = 0;
    logic cfg_ready, match, done, busy;
    logic [PW-1:0] cfg_pattern = '0, cfg_mask = '0;
    logic [LW-1:0] cfg_len = '0;
    logic [CW-1:0] cfg_target = '0, match_count;
    logic [1:0] present, nxt;
    int checks = 0, errors = 0;
    int m_st, m_len, m_tgt, m_cnt;
    bit m_ovl;
    logic [PW-1:0] m_pat, m_msk;
    bit q[$];

    seq_scan_ctrl #(.PW(PW), .LW(LW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
`ifdef SCAN_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .start(start), .abort(abort), .in_valid(in_valid), .in(in), .match(match),
        .match_count(match_count), .done(done), .busy(busy), .present(present), .next(nxt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = S_IDLE; m_len = 0; m_tgt = 0; m_cnt = 0; m_ovl = 0; m_pat = '0; m_msk = '0;
        q.delete();
    endfunction

    // A match needs len-1 stored bits since the last clear; pattern bit 0 is the newest bit.
    function automatic bit model_match();
        int n;
        bit b;
        if (m_st != S_SCAN || !in_valid || abort) return 0;
        n = q.size();
        if (n < m_len - 1) return 0;
        for (int k = 0; k < m_len; k++) begin
            b = (k == 0) ? in : q[n - k];
            if (!m_msk[k] && b != m_pat[k]) return 0;
        end
        return 1;
    endfunction

    function automatic int model_next(input bit em);
        bit fire, ok;
        fire = cfg_valid && m_st != S_SCAN;
        ok = cfg_len >= 1 && cfg_len <= PW;
        case (m_st)
            S_IDLE:  return fire && ok ? S_READY : S_IDLE;
            S_READY: return fire ? S_READY : start ? S_SCAN : S_READY;
            S_SCAN:  return abort ? S_READY : (em && m_tgt != 0 && m_cnt + 1 == m_tgt) ? S_DONE : S_SCAN;
            default: return fire ? (ok ? S_READY : S_DONE) : abort ? S_READY : start ? S_SCAN : S_DONE;
        endcase
    endfunction

    function automatic void model_update(input bit em);
        int n;
        n = model_next(em);
        if (cfg_valid && m_st != S_SCAN && cfg_len >= 1 && cfg_len <= PW) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
`ifdef SCAN_MASK_EN
            m_msk = cfg_mask;
`endif
        end
        if (m_st == S_SCAN && !abort && in_valid) begin
            q.push_back(in);
            if (q.size() > PW) void'(q.pop_front());
            if (em) begin
                if (m_cnt < 2**CW - 1) m_cnt++;
                if (!m_ovl) q.delete();
            end
        end
        if (m_st != S_SCAN && n == S_SCAN) begin
            m_cnt = 0;
            q.delete();
        end
        m_st = n;
    endfunction

    task automatic cycle();
        bit em;
        int en;
        @(negedge clk);
        em = model_match();
        en = model_next(em);
        check("match", match, em);
        check("next", nxt, en);
        check("present", present, m_st);
        check("match_count", match_count, m_cnt);
        check("done", done, m_st == S_DONE);
        check("busy", busy, m_st == S_SCAN);
        check("cfg_ready", cfg_ready, m_st != S_SCAN);
        @(posedge clk);
        model_update(em);
        #1;
    endtask

    task automatic cfg(input logic [PW-1:0] p, input int l, input bit o, input int t, input logic [PW-1:0] mk);
        cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o; cfg_target = CW'(t); cfg_mask = mk;
        cfg_valid = 1;
        cycle();
        cfg_valid = 0;
    endtask

    task automatic go();
        start = 1;
        cycle();
        start = 0;
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            in_valid = 1;
            in = bits[i];
            cycle();
        end
        in_valid = 0;
    endtask

    task automatic do_abort();
        abort = 1;
        cycle();
        abort = 0;
    endtask

    task automatic hard_reset();
        reset = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_present", present, 0);
        check("rst_count", match_count, 0);
        check("rst_match", match, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        reset = 1;

        start = 1;
        cycle();
        start = 0;
        check("idle_start_ignored", present, 0);

        cfg(8'b00011011, 5, 1, 0, '0);
        go();
        feed(32'b11011011, 8);
        check("ovl_count", match_count, 2);
        check("ovl_state", present, S_SCAN);

        do_abort();
        check("abort_ready", present, S_READY);
        check("abort_held", match_count, 2);
        cfg(8'b00011011, 5, 0, 0, '0);
        go();
        feed(32'b11011011, 8);
        check("novl_count", match_count, 1);

        do_abort();
        cfg(8'b1, 1, 1, 0, '0);
        go();
        feed(32'b111, 3);
        check("pre_rst_count", match_count, 3);
        #2;
        reset = 0;
        #1;
        check("async_present", present, 0);
        check("async_count", match_count, 0);
        check("async_done", done, 0);
        check("async_ready", cfg_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;

        cfg(8'b11, 2, 1, 3, '0);
        go();
        feed(32'b1111, 4);
        check("tgt_done", done, 1);
        check("tgt_present", present, S_DONE);
        check("tgt_ready", cfg_ready, 1);
        check("tgt_count", match_count, 3);
        feed(32'b11, 2);
        check("done_held", match_count, 3);
        go();
        check("done_restart", present, S_SCAN);
        check("done_restart_cnt", match_count, 0);

        hard_reset();
        cfg(8'h5, 0, 0, 0, '0);
        check("len0_idle", present, 0);
        cfg(8'h5, 12, 0, 0, '0);
        check("len12_idle", present, 0);
        cfg(8'h3, 2, 0, 0, '0);
        cfg_pattern = 8'h1; cfg_len = 1; cfg_overlap = 1; cfg_target = 2; cfg_valid = 1; start = 1;
        cycle();
        cfg_valid = 0; start = 0;
        check("cfg_beats_start", present, S_READY);
        go();
        feed(32'b11, 2);
        check("new_cfg_used", present, S_DONE);

`ifdef SCAN_MASK_EN
        hard_reset();
        cfg(8'b101, 3, 0, 0, 8'b010);
        go();
        feed(32'b111, 3);
        check("mask_hit", match_count, 1);
        feed(32'b100, 3);
        check("mask_miss", match_count, 1);
`endif

        hard_reset();
        for (int i = 0; i < 4000; i++) begin
            cfg_valid = ($urandom % 8) == 0;
            cfg_len = ($urandom % 10 == 0) ? LW'($urandom % 2 ? 0 : $urandom_range(9, 15))
                    : LW'(($urandom % 4 == 0) ? $urandom_range(1, 8) : $urandom_range(1, 3));
            cfg_pattern = PW'($urandom);
            cfg_overlap = $urandom % 2;
            cfg_target = CW'($urandom_range(0, 4));
            cfg_mask = PW'($urandom & $urandom);
            start = ($urandom % 6) == 0;
            abort = ($urandom % 30) == 0;
            in_valid = ($urandom % 4) != 0;
            in = $urandom % 2;
            cycle();
        end
        cfg_valid = 0; start = 0; abort = 0; in_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Run-time configurable serial pattern-scan controller.
- Accepts a pattern configuration (bits, length, overlap mode, match target) over a valid/ready handshake.
- Sequences a Mealy-style serial detector over a gated bit stream, counts matches, and signals completion.
- Sits between a config master and the serial input path; replaces fixed hard-coded detectors (e.g. 11011) with one programmable block.

Parameters:
- PW, 8, maximum pattern width in bits.
- LW, 4, width of cfg_len; must satisfy 2**LW > PW.
- CW, 8, width of match counter and cfg_target.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config accept; handshake completes when cfg_valid&cfg_ready at a clk edge.
- cfg_pattern  input  PW  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LW  pattern length, legal range 1..PW.
- cfg_overlap  input  1  1 = overlapping matches allowed.
- cfg_target  input  CW  number of matches that ends a scan; 0 = unlimited.
- start  input  1  begin scan.
- abort  input  1  stop scan.
- in_valid  input  1  serial bit qualifier.
- in  input  1  serial data bit.
- match  output  1  Mealy match pulse (combinational).
- match_count  output  CW  matches counted in the current scan.
- done  output  1  target reached.
- busy  output  1  high in SCAN.
- present  output  2  current state.
- next  output  2  next state (combinational).

Behaviour:
- States: IDLE=00, READY=01, SCAN=10, DONE=11.
- Reset (async assert, sync-to-clk deassert not required):
  - State=IDLE; pattern/len/overlap/target regs, history, fill counter and match_count cleared.
  - match=0, done=0, busy=0, cfg_ready=1.
- cfg_ready=1 in IDLE, READY and DONE; 0 in SCAN.
- Config acceptance:
  - Legal cfg_len latches all cfg_* fields and goes to READY.
  - cfg_len=0 or cfg_len>PW: handshake completes, nothing latched, state unchanged.
- IDLE: start is ignored.
- READY: start -> SCAN; clears history, fill counter and match_count that edge. cfg_valid and start in the same cycle: config wins, start ignored.
- SCAN:
  - Each in_valid cycle shifts in into the history; fill counter increments, saturating at len.
  - in_valid=0: no shift, match=0.
  - match=1 combinationally when in_valid=1, fill>=len-1, and {history[len-2:0],in} == pattern[len-1:0] (len=1: in==pattern[0]).
  - On a match edge: match_count+1. Overlap=0: fill counter cleared (history bits discarded). Overlap=1: fill kept.
  - target!=0 and match_count+1==target -> DONE on that edge.
  - target=0: match_count saturates at 2**CW-1 and never reaches DONE.
  - abort=1 -> READY next edge; match forced 0 that cycle; match_count held.
  - start in SCAN is ignored.
- DONE:
  - done=1 (level); match=0; match_count held.
  - start -> SCAN (count cleared).
  - Legal config -> READY.
  - abort -> READY.
- Latency: match is same-cycle as the completing bit; match_count, done and present update at the following edge.
- next equals the state present will take at the coming edge, including abort and config priority. Priority: config > abort > start.

Optional Feature:
- Macro SCAN_MASK_EN.
- Defined: adds input port cfg_mask [PW-1:0], latched with config. A mask bit of 1 makes that pattern position don't-care in the compare.
- Undefined: no cfg_mask port; exact compare only.

Test Plan:
- Reset=0 mid-SCAN with count=3 -> immediately present=00, match_count=0, done=0, cfg_ready=1.
- Config pattern=8'b00011011, len=5, overlap=1, target=0; start; stream 1,1,0,1,1,0,1,1 -> match pulses on bits 5 and 8, match_count=2, state stays SCAN.
- Same stream with overlap=0 -> single match on bit 5, match_count=1.
- Pattern 2'b11, len=2, overlap=1, target=3; stream 1,1,1,1 -> matches on bits 2,3,4; done=1 after bit 4; present=11; cfg_ready=1.
- cfg_len=0 offered in IDLE -> handshake completes, state stays 00. cfg_valid+start together in READY -> stays READY with the new config.
- With SCAN_MASK_EN: pattern 3'b101, mask 3'b010, len=3; stream 1,1,1 -> match on bit 3. Stream 1,0,0 -> no match.
